// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: op codes, FSM states, and the
// running inter-bit state carried from one slice evaluation to the next.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NAND = 3'b011,
    OP_XOR  = 3'b100,
    OP_EQ   = 3'b101,
    OP_GT   = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic borrow;
    logic eq;
    logic gt;
  } run_state_t;

  localparam run_state_t RUN_STATE_PRESET = '{carry: 1'b0, borrow: 1'b0, eq: 1'b1, gt: 1'b0};

  // Picks which running-state bit is reported as the flag for a given op.
  function automatic logic sel_flag(input op_e op, input run_state_t st);
    logic f;
    case (op)
      OP_ADD:  f = st.carry;
      OP_SUB:  f = st.borrow;
      OP_EQ:   f = st.eq;
      OP_GT:   f = st.gt;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: combines one bit of A and B with the incoming running
// state and produces the result bit plus the running state for the next bit.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  op_e        op,
  input  run_state_t st_in,
  output logic       res,
  output run_state_t st_out
);

  // Result bit per op and next running state; all four state bits are
  // tracked every bit so the flag can be selected at the end.
  always_comb begin
    res    = 1'b0;
    st_out = st_in;
    case (op)
      OP_ADD:  res = a ^ b ^ st_in.carry;
      OP_SUB:  res = a ^ b ^ st_in.borrow;
      OP_AND:  res = a & b;
      OP_NAND: res = ~(a & b);
      OP_XOR:  res = a ^ b;
      default: res = 1'b0;
    endcase
    st_out.carry  = (a & b) | (a & st_in.carry) | (b & st_in.carry);
    st_out.borrow = (~a & b) | (~(a ^ b) & st_in.borrow);
    st_out.eq     = st_in.eq & ~(a ^ b);
    // LSB first: a later (more significant) differing bit overrides.
    st_out.gt     = (a ^ b) ? (a & ~b) : st_in.gt;
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: latches operands on start, feeds one bit per
// clock through alu_bit_slice LSB first, and pulses done with the result.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready; waiting for start, result/flag hold last operation
//   RUN     | one bit per cycle, counter 0..WIDTH-1
//   DONE    | one-cycle done pulse; result and flag valid
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state, state_nxt;
  logic             load, step, last;
  op_e              op_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, res_msb;
  logic [CW-1:0]    cnt;
  run_state_t       st_q, st_nxt;
  logic             res_bit, flag_q;

  assign last   = (cnt == LAST);
  assign result = res_q;
  assign flag   = flag_q;

  alu_bit_slice u_slice (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .op     (op_q),
    .st_in  (st_q),
    .res    (res_bit),
    .st_out (st_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The new result bit enters at the MSB end as the register shifts right.
  always_comb begin
    res_msb            = '0;
    res_msb[WIDTH-1]   = res_bit;
  end

  // Operand shift registers, result assembly, running state and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_ADD;
      a_sh   <= '0;
      b_sh   <= '0;
      res_q  <= '0;
      cnt    <= '0;
      st_q   <= RUN_STATE_PRESET;
      flag_q <= 1'b0;
    end else if (load) begin
      op_q <= op_e'(op);
      a_sh <= a_in;
      b_sh <= b_in;
      cnt  <= '0;
      st_q <= RUN_STATE_PRESET;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      res_q <= (res_q >> 1) | res_msb;
      st_q  <= st_nxt;
      if (last) flag_q <= sel_flag(op_q, st_nxt);
      else      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: WIDTH=8 instance checked every cycle against a
// cycle-count/arithmetic model, plus a WIDTH=1 instance checked directly.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         ready, busy, done, flag;
  logic [W-1:0] result;

  logic         start1 = 1'b0;
  logic [2:0]   op1 = 3'd0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         ready1, busy1, done1, flag1;
  logic [0:0]   result1;

  int checks = 0;
  int errors = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .ready(ready), .busy(busy), .done(done), .result(result), .flag(flag)
  );

  alu_serial_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .a_in(a1), .b_in(b1),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1), .flag(flag1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {flag, result} for a w-bit operation.
  function automatic logic [32:0] ref_op(input int w, input logic [2:0] o,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, aa, bb, s, r;
    logic f;
    m = (64'd1 << w) - 64'd1;
    aa = {32'd0, a} & m;
    bb = {32'd0, b} & m;
    s = aa + bb;
    r = 64'd0;
    f = 1'b0;
    case (o)
      3'd0: begin r = s & m; f = s[w]; end
      3'd1: begin r = (aa - bb) & m; f = (aa < bb); end
      3'd2: r = aa & bb;
      3'd3: r = ~(aa & bb) & m;
      3'd4: r = aa ^ bb;
      3'd5: f = (aa == bb);
      3'd6: f = (aa > bb);
      default: ;
    endcase
    return {f, r[31:0]};
  endfunction

  // Model: m_t = edges since acceptance (-1 idle); RUN for t=1..W, DONE at W+1.
  int          m_t = -1;
  logic [32:0] m_pend = '0;
  logic [W-1:0] m_res = '0;
  logic        m_flag = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = -1; m_res = '0; m_flag = 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        m_pend = ref_op(W, op, 32'(a_in), 32'(b_in));
        m_t = 1;
      end
    end else if (m_t == W + 1) begin
      m_t = -1;
    end else begin
      m_t = m_t + 1;
      if (m_t == W + 1) begin
        m_res  = m_pend[W-1:0];
        m_flag = m_pend[32];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", ready, m_t < 0);
      chk("busy", busy, (m_t >= 1) && (m_t <= W));
      chk("done", done, m_t == W + 1);
      if (m_t < 0 || m_t == W + 1) begin
        chk("result_hold", result, m_res);
        chk("flag_hold", flag, m_flag);
      end
    end
  end

  // Issue one op on the WIDTH=8 instance; optionally poke start during RUN.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [32:0] exp, input string name, input int poke);
    int n;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    chk({name, "_ready_wait"}, ready, 1'b1);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a_in = W'($urandom); b_in = W'($urandom);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if (n == poke) begin
        start = 1'b1; op = 3'($urandom); a_in = W'($urandom); b_in = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({name, "_latency"}, 64'(n), 64'(W));
    chk({name, "_res"}, result, exp[W-1:0]);
    chk({name, "_flag"}, flag, exp[32]);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc[$];
    int n;
    logic [32:0] e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_flag", flag, 1'b0);

    // Pin the reference model with hand-computed values.
    chk("model_add", ref_op(8, 3'd0, 32'hFF, 32'h01), {1'b1, 32'h00});
    chk("model_sub", ref_op(8, 3'd1, 32'h03, 32'h05), {1'b1, 32'hFE});
    chk("model_nand", ref_op(8, 3'd3, 32'hCC, 32'hAA), {1'b0, 32'h77});
    chk("model_w1_add", ref_op(1, 3'd0, 32'h1, 32'h1), {1'b1, 32'h0});

    do_op(3'd0, 8'hFF, 8'h01, {1'b1, 32'h00}, "add_ff_01", -1);
    do_op(3'd1, 8'h03, 8'h05, {1'b1, 32'hFE}, "sub_03_05", -1);
    do_op(3'd1, 8'h05, 8'h03, {1'b0, 32'h02}, "sub_05_03", -1);
    do_op(3'd5, 8'hA5, 8'hA5, {1'b1, 32'h00}, "eq_same", -1);
    do_op(3'd5, 8'hA5, 8'hA4, {1'b0, 32'h00}, "eq_diff", -1);
    do_op(3'd6, 8'h80, 8'h7F, {1'b1, 32'h00}, "gt_80_7f", -1);
    do_op(3'd6, 8'h7F, 8'h80, {1'b0, 32'h00}, "gt_7f_80", -1);
    do_op(3'd2, 8'hCC, 8'hAA, {1'b0, 32'h88}, "and", -1);
    do_op(3'd3, 8'hCC, 8'hAA, {1'b0, 32'h77}, "nand", -1);
    do_op(3'd4, 8'hCC, 8'hAA, {1'b0, 32'h66}, "xor", -1);
    do_op(3'd7, 8'hCC, 8'hAA, {1'b0, 32'h00}, "rsvd", -1);
    do_op(3'd0, 8'h12, 8'h34, {1'b0, 32'h46}, "start_in_run", 3);
    do_op(3'd6, 8'h10, 8'h10, {1'b0, 32'h00}, "start_in_done_gt", 7);

    // Start held high: an operation every W+2 cycles.
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      op = 3'($urandom); a_in = W'($urandom); b_in = W'($urandom);
      @(negedge clk);
      if (done) done_cyc.push_back(c);
    end
    start = 1'b0;
    chk("b2b_count_min", 64'(done_cyc.size() >= 3), 64'd1);
    for (int i = 1; i < done_cyc.size(); i++)
      chk("b2b_period", 64'(done_cyc[i] - done_cyc[i-1]), 64'(W + 2));
    n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);

    // Asynchronous reset in the middle of an ADD.
    start = 1'b1; op = 3'd0; a_in = 8'hF0; b_in = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_result", result, 8'h00);
    chk("arst_flag", flag, 1'b0);
    @(negedge clk);
    chk("arst_no_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    do_op(3'd0, 8'h80, 8'h80, {1'b1, 32'h00}, "add_after_rst", -1);

    // WIDTH=1 instance: RUN lasts one cycle, done in the second cycle.
    start1 = 1'b1; op1 = 3'd0; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", busy1, 1'b1);
    chk("w1_done_early", done1, 1'b0);
    @(negedge clk);
    chk("w1_done", done1, 1'b1);
    chk("w1_add_res", result1, 1'b0);
    chk("w1_add_flag", flag1, 1'b1);
    @(negedge clk);
    chk("w1_ready", ready1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      op1 = 3'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      e = ref_op(1, op1, 32'(a1), 32'(b1));
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_rand_busy", busy1, 1'b1);
      @(negedge clk);
      chk("w1_rand_done", done1, 1'b1);
      chk("w1_rand_res", result1, e[0]);
      chk("w1_rand_flag", flag1, e[32]);
      @(negedge clk);
    end

    // Randomized operations on the WIDTH=8 instance.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom); ra = W'($urandom); rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      do_op(ro, ra, rb, ref_op(W, ro, 32'(ra), 32'(rb)), "rand", ($urandom_range(0, 3) == 0) ? 2 : -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
